// File: rtl/note_sequencer_if.sv
// Control inputs and playback/status outputs of note_sequencer, bundled as one port.
interface note_sequencer_if #(
    parameter int NOTE_W = 4,
    parameter int OCT_W  = 2,
    parameter int CNT_W  = 5
);
    logic [NOTE_W-1:0] note_in;
    logic [OCT_W-1:0]  octave_in;
    logic              note_valid;
    logic              rec_en;
    logic              play_start;
    logic              stop;
    logic              clear;
    logic              loop_en;
    logic [NOTE_W-1:0] note_out;
    logic [OCT_W-1:0]  octave_out;
    logic              note_out_valid;
    logic              playing;
    logic              recording;
    logic [CNT_W-1:0]  count;
    logic              full;
    logic              overflow;

    modport master (
        output note_in, octave_in, note_valid, rec_en, play_start, stop, clear, loop_en,
        input  note_out, octave_out, note_out_valid, playing, recording, count, full, overflow
    );

    modport slave (
        input  note_in, octave_in, note_valid, rec_en, play_start, stop, clear, loop_en,
        output note_out, octave_out, note_out_valid, playing, recording, count, full, overflow
    );
endinterface

// File: rtl/note_sequencer.sv
// Records timed notes into a small buffer and plays them back at tempo-tick resolution.
module note_sequencer #(
    parameter int DEPTH    = 16,
    parameter int NOTE_W   = 4,
    parameter int OCT_W    = 2,
    parameter int DUR_W    = 4,
    parameter int TICK_DIV = 12500000
) (
    input  logic            clk,
    input  logic            reset,
    note_sequencer_if.slave bus
);
    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int ENT_W  = NOTE_W + OCT_W;

    typedef enum logic [1:0] {IDLE, RECORD, PLAY} state_t;
    state_t state, state_next;

    logic [ENT_W-1:0]  ent_mem [DEPTH];
    logic [DUR_W-1:0]  dur_mem [DEPTH];

    logic [TICK_W-1:0] tick_cnt;
    logic [CNT_W-1:0]  count;
    logic [IDX_W-1:0]  index;
    logic [DUR_W-1:0]  dur_cnt;
    logic [DUR_W-1:0]  remain;
    logic [NOTE_W-1:0] note_q;
    logic [OCT_W-1:0]  oct_q;
    logic              valid_q;
    logic              overflow_q;
    logic              playing;
    logic              recording;
    logic              full;

    logic              tick;
    logic              accept;
    logic              wr_en;
    logic              fin_en;
    logic              advance;
    logic              last;
    logic [IDX_W-1:0]  wr_idx;
    logic [IDX_W-1:0]  fin_idx;
    logic [IDX_W-1:0]  next_idx;
    logic [DUR_W-1:0]  fin_val;

    assign tick = (tick_cnt == TICK_W'(TICK_DIV - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (!bus.stop && !bus.clear) begin
                    if (bus.play_start) begin
                        if (count != '0) state_next = PLAY;
                    end else if (bus.rec_en) begin
                        state_next = RECORD;
                    end
                end
            end
            RECORD: if (bus.stop || !bus.rec_en) state_next = IDLE;
            PLAY:   if (bus.stop || (advance && last && !bus.loop_en)) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        playing   = (state == PLAY);
        recording = (state == RECORD);
        full      = (count == CNT_W'(DEPTH));
    end

    // A note's duration is only known when the next note arrives or recording ends.
    always_comb begin
        accept   = (state == RECORD) && (state_next == RECORD) && bus.note_valid;
        wr_en    = accept && (count < CNT_W'(DEPTH));
        fin_en   = (count != '0) && (wr_en || ((state == RECORD) && (state_next != RECORD)));
        wr_idx   = IDX_W'(count);
        fin_idx  = IDX_W'(count - CNT_W'(1));
        fin_val  = (dur_cnt == '0) ? DUR_W'(1) : dur_cnt;
        advance  = (state == PLAY) && tick && (remain == DUR_W'(1));
        last     = (index == fin_idx);
        next_idx = last ? '0 : index + IDX_W'(1);
    end

    always_ff @(posedge clk) begin
        if (wr_en)  ent_mem[wr_idx]  <= {bus.note_in, bus.octave_in};
        if (fin_en) dur_mem[fin_idx] <= fin_val;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tick_cnt   <= '0;
            count      <= '0;
            index      <= '0;
            dur_cnt    <= '0;
            remain     <= '0;
            note_q     <= '0;
            oct_q      <= '0;
            valid_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            if ((state_next != state) || tick) tick_cnt <= '0;
            else                               tick_cnt <= tick_cnt + TICK_W'(1);

            unique case (state)
                IDLE: begin
                    if (!bus.stop && bus.clear) begin
                        count      <= '0;
                        overflow_q <= 1'b0;
                    end
                    if (state_next == RECORD) begin
                        count      <= '0;
                        overflow_q <= 1'b0;
                        dur_cnt    <= '0;
                    end
                    if (state_next == PLAY) begin
                        index           <= '0;
                        {note_q, oct_q} <= ent_mem[0];
                        remain          <= dur_mem[0];
                        valid_q         <= 1'b1;
                    end
                end
                RECORD: begin
                    if (wr_en) begin
                        count   <= count + CNT_W'(1);
                        dur_cnt <= '0;
                    end else begin
                        if (accept) overflow_q <= 1'b1;
                        if (tick && (dur_cnt != '1)) dur_cnt <= dur_cnt + DUR_W'(1);
                    end
                end
                PLAY: begin
                    if (state_next != PLAY) begin
                        valid_q <= 1'b0;
                    end else if (advance) begin
                        index           <= next_idx;
                        {note_q, oct_q} <= ent_mem[next_idx];
                        remain          <= dur_mem[next_idx];
                    end else if (tick) begin
                        remain <= remain - DUR_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.note_out       = note_q;
    assign bus.octave_out     = oct_q;
    assign bus.note_out_valid = valid_q;
    assign bus.playing        = playing;
    assign bus.recording      = recording;
    assign bus.count          = count;
    assign bus.full           = full;
    assign bus.overflow       = overflow_q;
endmodule
